// File: rtl/pwm_cmd_scheduler.sv
// pwm_cmd_scheduler: slew-limited PWM command words with heartbeat, host watchdog and estop.
// Build macro PWM_SCHED_REVERSE_DWELL_EN adds a zero-duty dwell of DWELL_PASSES passes before a direction flip.
//
// state | meaning
// IDLE  | waiting for the slew tick terminal count
// SLEW  | updating channel idx, one channel per cycle
module pwm_cmd_scheduler #(
    parameter int N_CH         = 4,
    parameter int CH_W         = 2,
    parameter int STEP         = 16,
    parameter int UPDATE_DIV   = 1000,
    parameter int HB_DIV       = 500000,
    parameter int WDT_CYCLES   = 25000000,
    parameter int DWELL_PASSES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [CH_W-1:0]      wr_chan,
    input  logic [10:0]          wr_duty,
    input  logic                 wr_dir,
    input  logic                 estop,
    output logic [13*N_CH-1:0]   cmd_out,
    output logic [N_CH-1:0]      at_target,
    output logic                 busy,
    output logic                 fault,
    output logic                 bad_chan
);

    localparam int TICK_W = $clog2(UPDATE_DIV + 1);
    localparam int HB_W   = $clog2(HB_DIV + 1);
    localparam int WDT_W  = $clog2(WDT_CYCLES + 1);
    localparam logic [10:0] STEP_D = 11'(STEP);
    localparam logic [11:0] STEP_X = 12'(STEP);

    typedef enum logic {IDLE = 1'b0, SLEW = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   idx, idx_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic [HB_W-1:0]   hb_cnt;
    logic              hb;
    logic [WDT_W-1:0]  wdt_cnt;

    logic [10:0]       cur_duty [N_CH];
    logic [10:0]       tgt_duty [N_CH];
    logic [N_CH-1:0]   cur_dir, tgt_dir;

    logic              wr_acc, tick, wdt_trip;
    logic [10:0]       sel_cur, sel_tgt, slew_duty;
    logic              sel_cdir, sel_tdir, slew_dir, can_flip;
    logic [11:0]       gap;

    assign wr_ready = !estop;
    assign wr_acc   = wr_valid && wr_ready;
    assign tick     = !estop && (tick_cnt == TICK_W'(UPDATE_DIV - 1));
    assign wdt_trip = !wr_acc && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
    assign busy     = (state == SLEW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (estop) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: if (tick) begin
                    state_nxt = SLEW;
                    idx_nxt   = '0;
                end
                SLEW: if (idx == CH_W'(N_CH - 1)) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef PWM_SCHED_REVERSE_DWELL_EN
    localparam int DW_W = $clog2(DWELL_PASSES + 1);
    logic [DW_W-1:0] dwell_cnt [N_CH];
    logic [DW_W-1:0] sel_dwell;
`endif

    // Slew step for the channel currently addressed by idx; reads the pre-write target.
    always_comb begin
        sel_cur  = '0;
        sel_tgt  = '0;
        sel_cdir = 1'b0;
        sel_tdir = 1'b0;
`ifdef PWM_SCHED_REVERSE_DWELL_EN
        sel_dwell = '0;
`endif
        for (int i = 0; i < N_CH; i++) begin
            if (idx == CH_W'(i)) begin
                sel_cur  = cur_duty[i];
                sel_tgt  = tgt_duty[i];
                sel_cdir = cur_dir[i];
                sel_tdir = tgt_dir[i];
`ifdef PWM_SCHED_REVERSE_DWELL_EN
                sel_dwell = dwell_cnt[i];
`endif
            end
        end
`ifdef PWM_SCHED_REVERSE_DWELL_EN
        can_flip = (sel_dwell == DW_W'(DWELL_PASSES));
`else
        can_flip = (DWELL_PASSES >= 0);
`endif
        gap       = '0;
        slew_duty = sel_cur;
        slew_dir  = sel_cdir;
        if (sel_cdir != sel_tdir) begin
            if (sel_cur != '0)
                slew_duty = (sel_cur > STEP_D) ? sel_cur - STEP_D : '0;
            else if (can_flip)
                slew_dir = sel_tdir;
        end else if (sel_tgt > sel_cur) begin
            gap       = {1'b0, sel_tgt} - {1'b0, sel_cur};
            slew_duty = (gap > STEP_X) ? sel_cur + STEP_D : sel_tgt;
        end else begin
            gap       = {1'b0, sel_cur} - {1'b0, sel_tgt};
            slew_duty = (gap > STEP_X) ? sel_cur - STEP_D : sel_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cur_duty[i] <= '0;
                tgt_duty[i] <= '0;
            end
            cur_dir <= '0;
            tgt_dir <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (estop) begin
                    cur_duty[i] <= '0;
                    tgt_duty[i] <= '0;
                end else begin
                    if (state == SLEW && idx == CH_W'(i)) begin
                        cur_duty[i] <= slew_duty;
                        cur_dir[i]  <= slew_dir;
                    end
                    if (wr_acc && wr_chan == CH_W'(i)) begin
                        tgt_duty[i] <= wr_duty;
                        tgt_dir[i]  <= wr_dir;
                    end else if (wdt_trip) begin
                        tgt_duty[i] <= '0;
                    end
                end
            end
        end
    end

`ifdef PWM_SCHED_REVERSE_DWELL_EN
    // Dwell counts zero-duty passes at a pending reversal; any pass without one clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) dwell_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!estop && state == SLEW && idx == CH_W'(i)) begin
                    if (sel_cdir != sel_tdir && sel_cur == '0 && !can_flip)
                        dwell_cnt[i] <= dwell_cnt[i] + 1'b1;
                    else
                        dwell_cnt[i] <= '0;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt  <= '0;
            hb_cnt    <= '0;
            hb        <= 1'b0;
            wdt_cnt   <= '0;
            fault     <= 1'b0;
            bad_chan  <= 1'b0;
            cmd_out   <= '0;
            at_target <= '1;
        end else begin
            if (estop || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;

            if (!fault && !estop) begin
                if (hb_cnt == HB_W'(HB_DIV - 1)) begin
                    hb_cnt <= '0;
                    hb     <= !hb;
                end else begin
                    hb_cnt <= hb_cnt + 1'b1;
                end
            end

            if (wr_acc) begin
                wdt_cnt <= '0;
                fault   <= 1'b0;
            end else if (wdt_cnt != WDT_W'(WDT_CYCLES)) begin
                wdt_cnt <= wdt_cnt + 1'b1;
                if (wdt_trip) fault <= 1'b1;
            end

            bad_chan <= wr_acc && (32'(wr_chan) >= 32'(N_CH));

            // Duty is blanked straight from estop so the outputs drop one cycle after it asserts.
            for (int i = 0; i < N_CH; i++) begin
                cmd_out[13*i +: 13] <= {hb, cur_dir[i], estop ? 11'd0 : cur_duty[i]};
                at_target[i]        <= (cur_duty[i] == tgt_duty[i]) && (cur_dir[i] == tgt_dir[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_cmd_scheduler.sv
// Self-checking bench for pwm_cmd_scheduler: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model built from the block's rules.
module tb_pwm_cmd_scheduler;

    localparam int N_CH       = 4;
    localparam int CH_W       = 3;
    localparam int STEP       = 16;
    localparam int UPDATE_DIV = 10;
    localparam int HB_DIV     = 8;
    localparam int WDT_CYCLES = 100;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                wr_valid = 1'b0;
    logic                wr_ready;
    logic [CH_W-1:0]     wr_chan = '0;
    logic [10:0]         wr_duty = '0;
    logic                wr_dir = 1'b0;
    logic                estop = 1'b0;
    logic [13*N_CH-1:0]  cmd_out;
    logic [N_CH-1:0]     at_target;
    logic                busy;
    logic                fault;
    logic                bad_chan;

    int checks = 0;
    int errors = 0;

    pwm_cmd_scheduler #(
        .N_CH(N_CH), .CH_W(CH_W), .STEP(STEP), .UPDATE_DIV(UPDATE_DIV),
        .HB_DIV(HB_DIV), .WDT_CYCLES(WDT_CYCLES), .DWELL_PASSES(4)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_chan(wr_chan), .wr_duty(wr_duty), .wr_dir(wr_dir), .estop(estop),
        .cmd_out(cmd_out), .at_target(at_target), .busy(busy), .fault(fault),
        .bad_chan(bad_chan)
    );

    always #5 clk = ~clk;

    // Reference model: targets/current values as plain ints, a slew pass as a queue of channels.
    int  m_tgt_d [N_CH];
    int  m_cur_d [N_CH];
    bit  m_tgt_dir [N_CH];
    bit  m_cur_dir [N_CH];
    int  m_phase, m_wdt, m_hbcnt;
    bit  m_fault, m_hb;
    int  pend[$];
    logic [13*N_CH-1:0] exp_cmd;
    logic [N_CH-1:0]    exp_at;
    bit  exp_bad;

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_tgt_d[i] = 0; m_cur_d[i] = 0; m_tgt_dir[i] = 0; m_cur_dir[i] = 0;
        end
        m_phase = 0; m_wdt = 0; m_hbcnt = 0; m_fault = 0; m_hb = 0;
        pend.delete();
        exp_cmd = '0; exp_at = '1; exp_bad = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge, then wait past it.
    task automatic step(input bit v, input int ch, input int d, input bit dr, input bit es);
        int k, mv;
        for (int i = 0; i < N_CH; i++) begin
            exp_cmd[13*i +: 13] = {m_hb, m_cur_dir[i], es ? 11'd0 : 11'(m_cur_d[i])};
            exp_at[i] = (m_cur_d[i] == m_tgt_d[i]) && (m_cur_dir[i] == m_tgt_dir[i]);
        end
        exp_bad = v && !es && (ch >= N_CH);
        if (!m_fault && !es) begin
            m_hbcnt++;
            if (m_hbcnt == HB_DIV) begin m_hbcnt = 0; m_hb = !m_hb; end
        end
        if (es) begin
            pend.delete();
            m_phase = 0;
            for (int i = 0; i < N_CH; i++) m_cur_d[i] = 0;
        end else begin
            if (pend.size() > 0) begin
                k = pend.pop_front();
                if (m_cur_dir[k] != m_tgt_dir[k]) begin
                    if (m_cur_d[k] > 0) m_cur_d[k] -= (m_cur_d[k] < STEP) ? m_cur_d[k] : STEP;
                    else m_cur_dir[k] = m_tgt_dir[k];
                end else begin
                    mv = m_tgt_d[k] - m_cur_d[k];
                    if (mv > STEP) mv = STEP;
                    if (mv < -STEP) mv = -STEP;
                    m_cur_d[k] += mv;
                end
            end
            if (m_phase == UPDATE_DIV - 1) begin
                m_phase = 0;
                for (int i = 0; i < N_CH; i++) pend.push_back(i);
            end else begin
                m_phase++;
            end
        end
        if (v && !es) begin
            m_wdt = 0; m_fault = 0;
            if (ch < N_CH) begin m_tgt_d[ch] = d; m_tgt_dir[ch] = dr; end
        end else if (m_wdt < WDT_CYCLES) begin
            m_wdt++;
            if (m_wdt == WDT_CYCLES) begin
                m_fault = 1;
                for (int i = 0; i < N_CH; i++) m_tgt_d[i] = 0;
            end
        end
        if (es) for (int i = 0; i < N_CH; i++) m_tgt_d[i] = 0;
        wr_valid = v; wr_chan = CH_W'(ch); wr_duty = 11'(d); wr_dir = dr; estop = es;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wr_valid = 0; wr_chan = '0; wr_duty = '0; wr_dir = 0; estop = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    function automatic int duty_of(input int ch);
        return int'(cmd_out[13*ch +: 11]);
    endfunction

    function automatic int dd_of(input int ch);
        return int'(cmd_out[13*ch +: 12]);
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (cmd_out !== '0) begin errors++; $display("FAIL reset_cmd got %h want 0", cmd_out); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", wr_ready); end
        checks++; if (at_target !== 4'b1111) begin errors++; $display("FAIL reset_at got %b want 1111", at_target); end
        checks++; if (busy !== 1'b0 || bad_chan !== 1'b0) begin errors++; $display("FAIL reset_busy_bad got %b%b want 00", busy, bad_chan); end
        step(1, 0, 200, 1, 0);
        step(1, 2, 300, 0, 0);
        idle(25);
        // Asynchronous assertion between edges must clear outputs without a clock.
        rst = 1'b0;
        #2;
        checks++; if (cmd_out !== '0 || at_target !== 4'b1111 || busy !== 1'b0) begin
            errors++; $display("FAIL async_reset got cmd=%h at=%b busy=%b want 0/1111/0", cmd_out, at_target, busy);
        end
        do_reset();
    endtask

    task automatic test_slew_up();
        int seq[$];
        int prev, cur;
        int want[3] = '{16, 32, 40};
        do_reset();
        step(1, 1, 40, 0, 0);
        prev = 0;
        for (int c = 0; c < 40; c++) begin
            step(0, 0, 0, 0, 0);
            cur = duty_of(1);
            if (cur != prev) seq.push_back(cur);
            prev = cur;
            checks++; if (cmd_out !== exp_cmd) begin errors++; $display("FAIL slew_up_model got %h want %h", cmd_out, exp_cmd); end
        end
        checks++; if (seq.size() != 3) begin errors++; $display("FAIL slew_up_len got %0d want 3", seq.size()); end
        for (int j = 0; j < 3; j++) begin
            cur = (j < seq.size()) ? seq[j] : -1;
            checks++; if (cur != want[j]) begin errors++; $display("FAIL slew_up_seq[%0d] got %0d want %0d", j, cur, want[j]); end
        end
        checks++; if (at_target[1] !== 1'b1) begin errors++; $display("FAIL slew_up_at got %b want 1", at_target[1]); end
        checks++; if (duty_of(0) != 0 || duty_of(2) != 0 || duty_of(3) != 0) begin
            errors++; $display("FAIL slew_up_others got %0d %0d %0d want 0 0 0", duty_of(0), duty_of(2), duty_of(3));
        end
    endtask

    task automatic test_reversal();
        int seq[$];
        int prev, cur;
        int want[5] = '{16, 0, 2048, 2064, 2068};
        do_reset();
        step(1, 2, 32, 0, 0);
        idle(40);
        checks++; if (dd_of(2) != 32) begin errors++; $display("FAIL rev_start got %0d want 32", dd_of(2)); end
        step(1, 2, 20, 1, 0);
        prev = dd_of(2);
        for (int c = 0; c < 70; c++) begin
            step(0, 0, 0, 0, 0);
            cur = dd_of(2);
            if (cur != prev) begin
                seq.push_back(cur);
                if (cur[11] != prev[11]) begin
                    checks++; if (cur[10:0] != 0) begin errors++; $display("FAIL rev_flip_duty got %0d want 0", cur[10:0]); end
                end
            end
            prev = cur;
        end
        checks++; if (seq.size() != 5) begin errors++; $display("FAIL rev_len got %0d want 5", seq.size()); end
        for (int j = 0; j < 5; j++) begin
            cur = (j < seq.size()) ? seq[j] : -1;
            checks++; if (cur != want[j]) begin errors++; $display("FAIL rev_seq[%0d] got %0d want %0d", j, cur, want[j]); end
        end
        checks++; if (cmd_out !== exp_cmd || at_target !== exp_at) begin
            errors++; $display("FAIL rev_model got %h/%b want %h/%b", cmd_out, at_target, exp_cmd, exp_at);
        end
    endtask

    task automatic test_watchdog();
        int seq[$];
        int prev, cur;
        int want[4] = '{48, 32, 16, 0};
        bit hb0, seen;
        do_reset();
        step(1, 0, 64, 0, 0);
        idle(99);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wdt_early got %b want 0", fault); end
        checks++; if (duty_of(0) != 64) begin errors++; $display("FAIL wdt_level got %0d want 64", duty_of(0)); end
        idle(1);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL wdt_trip got %b want 1", fault); end
        idle(2);
        hb0 = cmd_out[12];
        prev = duty_of(0);
        for (int c = 0; c < 50; c++) begin
            step(0, 0, 0, 0, 0);
            cur = duty_of(0);
            if (cur != prev) seq.push_back(cur);
            prev = cur;
        end
        checks++; if (seq.size() != 4) begin errors++; $display("FAIL wdt_ramp_len got %0d want 4", seq.size()); end
        for (int j = 0; j < 4; j++) begin
            cur = (j < seq.size()) ? seq[j] : -1;
            checks++; if (cur != want[j]) begin errors++; $display("FAIL wdt_ramp[%0d] got %0d want %0d", j, cur, want[j]); end
        end
        checks++; if (cmd_out[12] !== hb0) begin errors++; $display("FAIL wdt_hb_frozen got %b want %b", cmd_out[12], hb0); end
        step(1, 1, 0, 0, 0);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wdt_clear got %b want 0", fault); end
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step(0, 0, 0, 0, 0);
            if (cmd_out[12] !== hb0) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL wdt_hb_resume got frozen want toggling"); end
    endtask

    task automatic test_estop();
        bit found;
        int prev, first;
        do_reset();
        step(1, 3, 100, 0, 0);
        idle(35);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (busy === 1'b1) found = 1; else step(0, 0, 0, 0, 0);
        end
        checks++; if (!found) begin errors++; $display("FAIL estop_wait_busy got idle want busy"); end
        checks++; if (duty_of(3) == 0) begin errors++; $display("FAIL estop_pre got 0 want nonzero"); end
        step(0, 0, 0, 0, 1);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL estop_ready got %b want 0", wr_ready); end
        checks++; if (duty_of(0) != 0 || duty_of(1) != 0 || duty_of(2) != 0 || duty_of(3) != 0) begin
            errors++; $display("FAIL estop_duty got %h want all duty 0", cmd_out);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL estop_busy got %b want 0", busy); end
        prev = cmd_out[12];
        step(1, 3, 500, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        checks++; if (int'(cmd_out[12]) != prev || cmd_out !== exp_cmd) begin
            errors++; $display("FAIL estop_hold got %h want %h", cmd_out, exp_cmd);
        end
        step(1, 3, 100, 0, 0);
        first = -1;
        for (int c = 0; c < 25; c++) begin
            step(0, 0, 0, 0, 0);
            if (first < 0 && duty_of(3) != 0) first = duty_of(3);
        end
        checks++; if (first != 16) begin errors++; $display("FAIL estop_resume got %0d want 16", first); end
    endtask

    task automatic test_bad_chan();
        do_reset();
        step(1, 1, 50, 0, 0);
        idle(80);
        step(1, 4, 999, 1, 0);
        checks++; if (bad_chan !== 1'b1) begin errors++; $display("FAIL bad_pulse got %b want 1", bad_chan); end
        step(0, 0, 0, 0, 0);
        checks++; if (bad_chan !== 1'b0) begin errors++; $display("FAIL bad_width got %b want 0", bad_chan); end
        idle(30);
        checks++; if (at_target !== 4'b1111 || duty_of(1) != 50) begin
            errors++; $display("FAIL bad_targets got at=%b d1=%0d want 1111 50", at_target, duty_of(1));
        end
        idle(68);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL bad_wdt_cleared got %b want 0", fault); end
        idle(1);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL bad_wdt_trip got %b want 1", fault); end
    endtask

    task automatic test_random();
        bit v, dr, es, quiet;
        int ch, d, es_hold;
        do_reset();
        es_hold = 0; quiet = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) quiet = ($urandom_range(0, 2) == 0);
            v  = quiet ? 1'b0 : ($urandom_range(0, 9) < 3);
            ch = $urandom_range(0, 5);
            d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 80);
            dr = $urandom_range(0, 1);
            if (es_hold > 0) begin es = 1; es_hold--; end
            else begin
                es = 0;
                if ($urandom_range(0, 199) == 0) es_hold = $urandom_range(1, 4);
            end
            step(v, ch, d, dr, es);
            checks++; if (cmd_out !== exp_cmd) begin errors++; $display("FAIL rnd_cmd c=%0d got %h want %h", c, cmd_out, exp_cmd); end
            checks++; if (at_target !== exp_at) begin errors++; $display("FAIL rnd_at c=%0d got %b want %b", c, at_target, exp_at); end
            checks++; if (fault !== m_fault) begin errors++; $display("FAIL rnd_fault c=%0d got %b want %b", c, fault, m_fault); end
            checks++; if (busy !== (pend.size() > 0)) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, pend.size() > 0); end
            checks++; if (bad_chan !== exp_bad) begin errors++; $display("FAIL rnd_bad c=%0d got %b want %b", c, bad_chan, exp_bad); end
            checks++; if (wr_ready !== !es) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, wr_ready, !es); end
        end
    endtask

    initial begin
        test_reset();
        test_slew_up();
        test_reversal();
        test_watchdog();
        test_estop();
        test_bad_chan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_cmd_scheduler.md
Name: pwm_cmd_scheduler

Overview:
- Drives the 13-bit command words of N PWM channels: bits 10:0 duty, bit 11 direction, bit 12 heartbeat.
- Accepts host duty/direction targets through a valid/ready write port.
- Slew-limits each channel toward its target, forcing duty to 0 before any direction reversal.
- Toggles each channel's heartbeat while the host is alive; ramps everything to zero on host watchdog timeout or on estop.

Parameters:
- N_CH, 4: number of PWM channels.
- CH_W, 2: width of the channel index, at least clog2(N_CH).
- STEP, 16: maximum duty change per channel per slew pass.
- UPDATE_DIV, 1000: clock cycles between slew passes; must be greater than N_CH.
- HB_DIV, 500000: clock cycles between heartbeat toggles.
- WDT_CYCLES, 25000000: cycles without an accepted write before fault.
- DWELL_PASSES, 4: zero-duty passes held at reversal (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  host write request.
- wr_ready  out  1  scheduler can accept a write.
- wr_chan  in  CH_W  target channel index.
- wr_duty  in  11  target duty.
- wr_dir  in  1  target direction.
- estop  in  1  synchronous level-sensitive emergency stop.
- cmd_out  out  13*N_CH  channel i occupies [13i+12:13i]; registered.
- at_target  out  N_CH  per-channel current duty/dir equal to target.
- busy  out  1  slew pass in progress.
- fault  out  1  watchdog tripped.
- bad_chan  out  1  one-cycle pulse when a write addresses wr_chan >= N_CH.

Behaviour:
- Reset (rst=0), applied asynchronously:
  - cmd_out=0, all targets=0, all current values=0.
  - fault=0, busy=0, bad_chan=0, at_target=all 1.
  - All counters=0, FSM=IDLE.
- wr_ready = !estop (combinational).
- Write accepted when wr_valid & wr_ready:
  - Latches target duty/dir for wr_chan.
  - Clears the watchdog counter and fault.
  - If wr_chan >= N_CH: target unchanged, bad_chan pulses, but watchdog is still cleared.
- Slew tick counter runs 0..UPDATE_DIV-1; the terminal count starts a pass.
- FSM states:
  - IDLE: waits for the tick, then goes to SLEW with idx=0 and busy=1.
  - SLEW: handles one channel per cycle; when idx=N_CH-1, goes to IDLE with busy=0.
  - A pass therefore lasts exactly N_CH cycles.
- Per-channel update in SLEW (cur = current, tgt = target):
  - dir differs and cur_duty>0: cur_duty -= min(STEP, cur_duty).
  - dir differs and cur_duty==0: cur_dir <= tgt_dir; duty stays 0 this pass.
  - dir equal: cur_duty moves toward tgt_duty by min(STEP, |diff|). No overshoot, no wrap; 11-bit arithmetic with a 12-bit intermediate.
- Write and slew hit the same channel in the same cycle: the slew uses the old target; the new target applies from the next pass.
- Heartbeat:
  - Shared counter 0..HB_DIV-1; at terminal count every heartbeat bit toggles.
  - Frozen (held) while fault or estop.
- Watchdog:
  - Counter saturates at WDT_CYCLES; reaching it sets fault=1 and all tgt_duty=0, with tgt_dir unchanged.
  - Channels then ramp down at the normal slew rate.
- estop=1:
  - Next cycle all cur_duty=0 and tgt_duty=0; the heartbeat freezes.
  - Tick counter and FSM are held in IDLE.
  - On release the block resumes from zero duty.
- cmd_out is updated the cycle after cur changes; latency from tick to channel i's output change = i+2 cycles.
- at_target[i] is registered and reflects cur==tgt after each update.

Optional Feature:
- Macro: PWM_SCHED_REVERSE_DWELL_EN.
- Defined: at a reversal, once cur_duty reaches 0 the channel holds 0 for DWELL_PASSES further passes before flipping cur_dir. Each channel has its own dwell counter; a target change back to the original dir cancels the dwell.
- Undefined: dir flips on the first pass that finds cur_duty==0; DWELL_PASSES is unused.

Test Plan:
- Reset with estop=0 -> cmd_out=0, fault=0, wr_ready=1, at_target=4'b1111.
- UPDATE_DIV=10, STEP=16; write ch1 duty=40 dir=0 -> ch1 duty 16, 32, 40 over three passes; at_target[1]=1 after the third; other channels stay 0.
- ch2 at duty=32 dir=0; write duty=20 dir=1 -> duty 16, 0, then dir=1 at duty 0, then 16, 20. Never nonzero duty with a changed dir.
- HB_DIV=8, WDT_CYCLES=100, no writes after ch0 duty=64:
  - At cycle 100: fault=1, heartbeat frozen, ch0 ramps 48, 32, 16, 0.
  - Next write clears fault and heartbeat resumes.
- ch3 duty=100; assert estop mid-pass -> wr_ready=0 and all duty 0 next cycle; after release, write ch3=100 -> ramps from 0.
- Write wr_chan=4 (N_CH=4, CH_W=3) -> bad_chan pulses one cycle, targets unchanged, watchdog cleared.
